// File: rtl/dpram_byte_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dpram_byte_packer_pkg
//  Brief    : Shared types and helpers for the block-RAM write front ends.
//  Revision : 1.0  initial release
// ============================================================================
package dpram_byte_packer_pkg;

    // Packer control states; explicit one-bit encoding.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PACK = 1'b1
    } pack_state_t;

    // Width of a byte-lane index for a given lane count (at least one bit).
    function automatic int lane_width(input int bewidth);
        return (bewidth > 1) ? $clog2(bewidth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dpram_byte_packer_if.sv
`default_nettype none
// ============================================================================
//  Module   : dpram_byte_packer_if
//  Brief    : Byte-stream input, packet control and RAM write-port bundle.
//  Revision : 1.0  initial release
// ============================================================================
interface dpram_byte_packer_if
    import dpram_byte_packer_pkg::*;
#(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 16,
    parameter int BEWIDTH = DWIDTH / 8,
    parameter int LW      = lane_width(BEWIDTH),
    parameter int CNTW    = 16
);
    // packet control
    logic               start;
    logic [AWIDTH-1:0]  start_addr;
    logic [LW-1:0]      start_lane;
    // byte stream
    logic               s_valid;
    logic [7:0]         s_data;
    logic               s_last;
    logic               s_ready;
    // RAM write port
    logic               wr_en;
    logic [AWIDTH-1:0]  wr_addr;
    logic [DWIDTH-1:0]  wr_data;
    logic [BEWIDTH-1:0] wr_be;
    // status
    logic               busy;
    logic               done;
    logic [CNTW-1:0]    done_bytes;

    modport master (
        output start, start_addr, start_lane, s_valid, s_data, s_last,
        input  s_ready, wr_en, wr_addr, wr_data, wr_be, busy, done, done_bytes
    );

    modport slave (
        input  start, start_addr, start_lane, s_valid, s_data, s_last,
        output s_ready, wr_en, wr_addr, wr_data, wr_be, busy, done, done_bytes
    );
endinterface
`default_nettype wire

// File: rtl/dpram_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module   : dpram_byte_packer
//  Brief    : Packs a valid/ready byte stream into byte-enabled RAM word
//             writes, with start lane, partial words, address wrap and
//             end-of-packet byte count.
//  Revision : 1.0  initial release
// ============================================================================
module dpram_byte_packer
    import dpram_byte_packer_pkg::*;
#(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 16,
    parameter int BEWIDTH = DWIDTH / 8,
    parameter int LW      = lane_width(BEWIDTH),
    parameter int CNTW    = 16
) (
    input  wire                  clk,
    input  wire                  rst,
    dpram_byte_packer_if.slave   bus
);

    generate
        if ((DWIDTH % 8) != 0) begin : g_dwidth_check
            $error("dpram_byte_packer: DWIDTH must be a multiple of 8");
        end
    endgenerate

    pack_state_t        r_state;
    pack_state_t        w_state_nxt;

    logic [AWIDTH-1:0]  r_addr;
    logic [LW-1:0]      r_lane;
    logic [CNTW-1:0]    r_count;
    logic [DWIDTH-1:0]  r_acc_data;
    logic [BEWIDTH-1:0] r_acc_be;

    logic               r_wr_en;
    logic [AWIDTH-1:0]  r_wr_addr;
    logic [DWIDTH-1:0]  r_wr_data;
    logic [BEWIDTH-1:0] r_wr_be;
    logic               r_done;
    logic [CNTW-1:0]    r_done_bytes;

    logic               w_busy;
    logic               w_ready;
    logic               w_accept;
    logic               w_emit;
    logic [LW-1:0]      w_start_lane;
    logic [CNTW-1:0]    w_count_nxt;
    logic [DWIDTH-1:0]  w_acc_data_nxt;
    logic [BEWIDTH-1:0] w_acc_be_nxt;

    // Handshake qualifiers; a word closes on its top lane or on the last byte.
    assign w_accept     = bus.s_valid && w_ready;
    assign w_emit       = w_accept && ((r_lane == LW'(BEWIDTH - 1)) || bus.s_last);
    assign w_start_lane = LW'(32'(bus.start_lane) % 32'(BEWIDTH));
    assign w_count_nxt  = (r_count == {CNTW{1'b1}}) ? r_count : r_count + 1'b1;

    // Accumulator contents after merging the incoming byte into its lane.
    always_comb begin
        w_acc_data_nxt = r_acc_data;
        w_acc_be_nxt   = r_acc_be;
        for (int i = 0; i < BEWIDTH; i++) begin
            if (r_lane == LW'(i)) begin
                w_acc_data_nxt[i*8 +: 8] = bus.s_data;
                w_acc_be_nxt[i]          = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic: start only matters in IDLE, last byte closes the packet.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start)              w_state_nxt = ST_PACK;
            ST_PACK: if (w_accept && bus.s_last) w_state_nxt = ST_IDLE;
            default:                             w_state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs; ready depends on the state register only.
    always_comb begin
        w_busy  = (r_state == ST_PACK);
        w_ready = (r_state == ST_PACK);
    end

    // Datapath: packet setup, byte accumulation and registered word writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_lane       <= '0;
            r_count      <= '0;
            r_acc_data   <= '0;
            r_acc_be     <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_be      <= '0;
            r_done       <= 1'b0;
            r_done_bytes <= '0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            if ((r_state == ST_IDLE) && bus.start) begin
                r_addr  <= bus.start_addr;
                r_lane  <= w_start_lane;
                r_count <= '0;
            end else if (w_accept) begin
                r_count <= w_count_nxt;
                if (w_emit) begin
                    r_wr_en    <= 1'b1;
                    r_wr_addr  <= r_addr;
                    r_wr_data  <= w_acc_data_nxt;
                    r_wr_be    <= w_acc_be_nxt;
                    r_acc_data <= '0;
                    r_acc_be   <= '0;
                    r_lane     <= '0;
                    r_addr     <= r_addr + 1'b1;
                    if (bus.s_last) begin
                        r_done       <= 1'b1;
                        r_done_bytes <= w_count_nxt;
                    end
                end else begin
                    r_acc_data <= w_acc_data_nxt;
                    r_acc_be   <= w_acc_be_nxt;
                    r_lane     <= r_lane + 1'b1;
                end
            end
        end
    end

    assign bus.s_ready    = w_ready;
    assign bus.busy       = w_busy;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.wr_be      = r_wr_be;
    assign bus.done       = r_done;
    assign bus.done_bytes = r_done_bytes;

endmodule
`default_nettype wire

// File: tb/tb_dpram_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dpram_byte_packer
//  Brief    : Self-checking bench for dpram_byte_packer (DWIDTH=32).
//  Revision : 1.0  initial release
// ============================================================================
module tb_dpram_byte_packer;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        done;
        logic [15:0] nbytes;
        logic        rdy;
    } wr_rec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    wr_rec_t    obs_q[$];
    wr_rec_t    exp_q[$];
    logic [7:0] pkt[$];

    always #5 clk = ~clk;

    dpram_byte_packer_if #(.DWIDTH(32), .AWIDTH(16), .CNTW(16)) bus ();

    dpram_byte_packer #(.DWIDTH(32), .AWIDTH(16), .CNTW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Capture every write-port strobe together with status seen in that cycle.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wr_rec_t r;
            r.addr   = bus.wr_addr;
            r.data   = bus.wr_data;
            r.be     = bus.wr_be;
            r.done   = bus.done;
            r.nbytes = bus.done_bytes;
            r.rdy    = bus.s_ready;
            obs_q.push_back(r);
        end
    end

    // Reference: byte i lands at absolute position lane+i; word = pos/4.
    task automatic model_packet(input logic [15:0] addr, input int lane);
        int n      = pkt.size();
        int nwords = (lane + n - 1) / 4 + 1;
        for (int k = 0; k < nwords; k++) begin
            wr_rec_t r;
            r.addr = addr + 16'(k);
            r.data = '0;
            r.be   = '0;
            for (int i = 0; i < n; i++) begin
                int p = lane + i;
                if (p / 4 == k) begin
                    r.data[(p % 4) * 8 +: 8] = pkt[i];
                    r.be[p % 4]              = 1'b1;
                end
            end
            r.done   = (k == nwords - 1);
            r.nbytes = r.done ? 16'(n) : 16'hxxxx;
            r.rdy    = !r.done;
            exp_q.push_back(r);
        end
    endtask

    // Called at a negedge; returns at the negedge of the final emit cycle.
    task automatic send_packet(input logic [15:0] addr, input int lane,
                               input bit gaps, input bit mid_start);
        model_packet(addr, lane);
        bus.start      = 1'b1;
        bus.start_addr = addr;
        bus.start_lane = 2'(lane);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < pkt.size(); i++) begin
            while (gaps && ($urandom_range(0, 2) == 0)) begin
                bus.s_valid = 1'b0;
                @(negedge clk);
            end
            bus.s_valid = 1'b1;
            bus.s_data  = pkt[i];
            bus.s_last  = (i == pkt.size() - 1);
            if (mid_start && i == 1) begin
                bus.start      = 1'b1;
                bus.start_addr = 16'h1234;
                bus.start_lane = 2'd3;
            end
            check("s_ready_in_packet", {63'd0, bus.s_ready}, 64'd1);
            @(negedge clk);
            bus.start = 1'b0;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic compare_writes(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            wr_rec_t o = obs_q.pop_front();
            wr_rec_t e = exp_q.pop_front();
            check({tag, "_addr"}, 64'(o.addr), 64'(e.addr));
            check({tag, "_data"}, 64'(o.data), 64'(e.data));
            check({tag, "_be"},   64'(o.be),   64'(e.be));
            check({tag, "_done"}, 64'(o.done), 64'(e.done));
            check({tag, "_rdy"},  64'(o.rdy),  64'(e.rdy));
            if (e.done) check({tag, "_nbytes"}, 64'(o.nbytes), 64'(e.nbytes));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic load_bytes(input int n, input logic [7:0] first);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(first + 8'(i));
    endtask

    task automatic load_random(input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.start_addr = '0; bus.start_lane = '0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_en",  {63'd0, bus.wr_en},   64'd0);
        check("rst_busy",   {63'd0, bus.busy},    64'd0);
        check("rst_ready",  {63'd0, bus.s_ready}, 64'd0);
        check("rst_done",   {63'd0, bus.done},    64'd0);
        check("rst_wr_addr", 64'(bus.wr_addr),    64'd0);
        check("rst_wr_data", 64'(bus.wr_data),    64'd0);
        check("rst_wr_be",   64'(bus.wr_be),      64'd0);
        check("rst_nbytes",  64'(bus.done_bytes), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Two full words.
        load_bytes(8, 8'h01);
        send_packet(16'h0010, 0, 1'b0, 1'b0);
        compare_writes("full_words");

        // Start lane 2, partial words on both ends.
        pkt.delete(); pkt.push_back(8'hAA); pkt.push_back(8'hBB); pkt.push_back(8'hCC);
        send_packet(16'h0020, 2, 1'b0, 1'b0);
        compare_writes("lane2");

        // Single byte packet.
        pkt.delete(); pkt.push_back(8'hEE);
        send_packet(16'h0005, 0, 1'b0, 1'b0);
        compare_writes("single");

        // Address wrap.
        load_bytes(5, 8'h30);
        send_packet(16'hFFFF, 0, 1'b0, 1'b0);
        compare_writes("wrap");

        // Gappy stream with an ignored mid-packet start.
        load_bytes(8, 8'h01);
        send_packet(16'h0010, 0, 1'b1, 1'b1);
        compare_writes("gaps_midstart");

        // Reset mid-packet: buffered bytes vanish, nothing written.
        bus.start = 1'b1; bus.start_addr = 16'h0300; bus.start_lane = 2'd0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.s_valid = 1'b1; bus.s_data = 8'h50 + 8'(i); bus.s_last = 1'b0;
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy",  {63'd0, bus.busy},    64'd0);
        check("rst_mid_ready", {63'd0, bus.s_ready}, 64'd0);
        repeat (4) @(negedge clk);
        check("rst_mid_no_write", 64'(obs_q.size()), 64'd0);
        load_bytes(3, 8'h60);
        send_packet(16'h0040, 1, 1'b0, 1'b0);
        compare_writes("after_rst");

        // Random packets, some chained back-to-back into the emit cycle.
        for (int t = 0; t < 20; t++) begin
            load_random($urandom_range(1, 12));
            send_packet(16'($urandom), $urandom_range(0, 3), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 0) compare_writes("random");
        end
        compare_writes("random_tail");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
